mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register.
- Resolves branches and jumps: PC source select and target.
- Performs data-memory load/store through a valid/ready request channel and a valid response channel, stalling the pipeline while an access is outstanding.
- Registers results into the MEM/WB boundary for writeback.

Parameters:
XLEN, 32, datapath/address width
RSP_TIMEOUT, 0, if >0, max cycles in WAIT_RSP before error pulse; 0 disables

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
PC_M  in  XLEN  instruction PC
PC_branch_M  in  XLEN  precomputed branch/jal target
imm_M  in  XLEN  immediate
rs2_rdata_M  in  XLEN  store data
rd_waddr_M  in  5  destination register
zero_M  in  1  ALU zero flag
alu_result_M  in  XLEN  ALU result / memory address
branch_M, MemWrite_M, jal_M, jalr_M  in  1 each  control
PMAItoReg_M  in  2  writeback select: 00 ALU, 01 MEM, 10 PC+4, 11 IMM
rd_wen_M  in  1  register write enable
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_req_we  out  1  1=store, 0=load
dmem_req_addr  out  XLEN  = alu_result_M
dmem_req_wdata  out  XLEN  = rs2_rdata_M
dmem_rsp_valid  in  1  load data valid
dmem_rsp_rdata  in  XLEN  load data
stall_o  out  1  freeze IF/ID/EX and EX/MEM register
PCSrc_M  out  1  take redirect
PC_target_M  out  XLEN  redirect address
dmem_timeout  out  1  one-cycle error pulse
alu_result_W, mem_rdata_W, pc_plus4_W, imm_W  out  XLEN  registered WB data
rd_waddr_W  out  5  registered
PMAItoReg_W  out  2  registered
rd_wen_W  out  1  registered

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all W outputs 0; dmem_timeout 0; timeout counter 0. Combinational outputs follow their equations with FSM=IDLE.
- load_M = (PMAItoReg_M==01) & rd_wen_M. store_M = MemWrite_M. mem_op = load_M | store_M.
- Branch logic, combinational:
  - PCSrc_M = (branch_M & zero_M) | jal_M | jalr_M.
  - PC_target_M = jalr_M ? (alu_result_M & ~1) : PC_branch_M.
- FSM states: IDLE, WAIT_RSP.
- IDLE:
  - dmem_req_valid = mem_op; dmem_req_we = store_M.
  - Store with ready=1: done this cycle, no stall.
  - Store with ready=0: stall_o=1; stay in IDLE with request held.
  - Load with ready=1: stall_o=1; next state WAIT_RSP.
  - Load with ready=0: stall_o=1; request held.
- WAIT_RSP:
  - dmem_req_valid=0; stall_o = ~dmem_rsp_valid.
  - On rsp_valid: capture rdata; next state IDLE.
- Upstream freezes on stall_o, so M inputs are stable while stalled. Request fields must not change while req_valid=1 and ready=0.
- dmem_rsp_valid in IDLE is ignored; no assertion is required.
- Minimum load latency is 2 cycles in M (accept, then response). A store is 1 cycle when ready=1.
- MEM/WB register, updated on each clk:
  - If stall_o=1: rd_wen_W<=0 (bubble); other W fields hold.
  - Else: alu_result_W<=alu_result_M; pc_plus4_W<=PC_M+4 (mod 2^XLEN); imm_W<=imm_M; rd_waddr_W<=rd_waddr_M; PMAItoReg_W<=PMAItoReg_M; rd_wen_W<=rd_wen_M.
  - mem_rdata_W <= dmem_rsp_rdata when in WAIT_RSP with rsp_valid, else holds.
- Timeout (RSP_TIMEOUT>0):
  - Counter clears on entering WAIT_RSP.
  - When count reaches RSP_TIMEOUT: pulse dmem_timeout for 1 cycle, complete with mem_rdata_W<=0, return to IDLE.
- Reset mid-access: FSM returns to IDLE immediately; an in-flight response after reset is ignored.
- Branch and memory ops never coincide; PCSrc_M is independent of stall_o.

Decomposition:
- Shared package: PMAItoReg encodings (WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10, WB_IMM=2'b11) and the FSM state enum.
- One natural sub-module: mem_dmem_fsm, covering the IDLE/WAIT_RSP machine, stall, request signals and timeout counter.
- Branch logic and the W register stay in the top level.

Test Plan:
- Reset mid-WAIT_RSP: assert rst_n=0 -> FSM IDLE, all W outputs 0; a later rsp_valid pulse has no effect.
- Store, ready=1: alu_result_M=0x100, rs2=0xDEADBEEF -> req_valid=1, we=1, addr=0x100, wdata=0xDEADBEEF for 1 cycle; stall_o=0.
- Load, ready=1, rsp_valid 3 cycles later with 0x12345678, rd=5 -> stall_o=1 for 3 cycles, rd_wen_W=0 during stall; then mem_rdata_W=0x12345678, rd_waddr_W=5, rd_wen_W=1.
- Store, ready low 2 cycles -> request fields stable, stall_o=1 for 2 cycles, then done on the ready cycle.
- Branch: branch_M=1, zero_M=1, PC_branch_M=0x40 -> PCSrc_M=1, target 0x40. Repeat with zero_M=0 -> PCSrc_M=0. jalr with alu_result_M=0x81 -> target 0x80.
- RSP_TIMEOUT=4, load with no response -> dmem_timeout pulses after 4 cycles in WAIT_RSP, mem_rdata_W=0, stall_o released.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: writeback-select encodings, the data-memory FSM states,
// and a load-decode helper.
package mem_stage_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_RSP = 1'b1
  } dmem_state_e;

  // An instruction is a load when it writes back memory data into a live destination.
  function automatic logic is_load(input logic [1:0] wb_sel, input logic rd_wen);
    return (wb_sel == WB_MEM) & rd_wen;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory channel: a valid/ready request channel plus a valid-only response channel.
// The master modport is the MEM stage side; the slave modport is the memory side.
interface mem_stage_if #(
  parameter int XLEN = 32
);

  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_req_we;
  logic [XLEN-1:0] dmem_req_addr;
  logic [XLEN-1:0] dmem_req_wdata;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rsp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

endinterface

// File: rtl/mem_dmem_fsm.sv
// Data-memory access sequencer: issues requests, waits for load responses, and drives the pipeline stall.
// A store completes in the cycle it is accepted. A load takes the accept cycle plus at least one response cycle.
module mem_dmem_fsm
  import mem_stage_pkg::*;
#(
  parameter int RSP_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic store_i,
  input  logic req_ready_i,
  input  logic rsp_valid_i,
  output logic req_valid_o,
  output logic req_we_o,
  output logic stall_o,
  output logic rsp_capture_o,
  output logic timeout_hit_o,
  output logic dmem_timeout_o
);

  localparam int CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);

  dmem_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;
  logic          in_idle;
  logic          ld;

  always_comb begin
    in_idle = (state_q == ST_IDLE);
    // When both a store and a load are decoded, the store wins so that the request and the stall agree.
    ld      = load_i & ~store_i;

    req_valid_o   = in_idle & (ld | store_i);
    req_we_o      = in_idle & store_i;
    rsp_capture_o = ~in_idle & rsp_valid_i;
    timeout_hit_o = (RSP_TIMEOUT > 0) && !in_idle && !rsp_valid_i && (cnt_q == TO_LAST);
    // The timeout cycle releases the stall so that the frozen load retires instead of being re-issued.
    stall_o       = in_idle ? (ld | (store_i & ~req_ready_i))
                            : ~(rsp_valid_i | timeout_hit_o);

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ld && req_ready_i) begin
          state_d = ST_WAIT_RSP;
          cnt_d   = '0;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_valid_i || timeout_hit_o) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_hit_o;
    end
  end

  assign dmem_timeout_o = timeout_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: resolves branches and jumps, sequences data-memory accesses, and registers the MEM/WB boundary.
// Latency: one cycle into WB, and the stage stalls while a memory access is outstanding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RSP_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  PC_M,
  input  logic [XLEN-1:0]  PC_branch_M,
  input  logic [XLEN-1:0]  imm_M,
  input  logic [XLEN-1:0]  rs2_rdata_M,
  input  logic [4:0]       rd_waddr_M,
  input  logic             zero_M,
  input  logic [XLEN-1:0]  alu_result_M,
  input  logic             branch_M,
  input  logic             MemWrite_M,
  input  logic             jal_M,
  input  logic             jalr_M,
  input  logic [1:0]       PMAItoReg_M,
  input  logic             rd_wen_M,
  mem_stage_if.master      dmem,
  output logic             stall_o,
  output logic             PCSrc_M,
  output logic [XLEN-1:0]  PC_target_M,
  output logic             dmem_timeout,
  output logic [XLEN-1:0]  alu_result_W,
  output logic [XLEN-1:0]  mem_rdata_W,
  output logic [XLEN-1:0]  pc_plus4_W,
  output logic [XLEN-1:0]  imm_W,
  output logic [4:0]       rd_waddr_W,
  output logic [1:0]       PMAItoReg_W,
  output logic             rd_wen_W
);

  logic load_M;
  logic rsp_capture;
  logic timeout_hit;

  assign load_M = is_load(PMAItoReg_M, rd_wen_M);

  assign PCSrc_M     = (branch_M & zero_M) | jal_M | jalr_M;
  assign PC_target_M = jalr_M ? {alu_result_M[XLEN-1:1], 1'b0} : PC_branch_M;

  assign dmem.dmem_req_addr  = alu_result_M;
  assign dmem.dmem_req_wdata = rs2_rdata_M;

  mem_dmem_fsm #(
    .RSP_TIMEOUT (RSP_TIMEOUT)
  ) u_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_i         (load_M),
    .store_i        (MemWrite_M),
    .req_ready_i    (dmem.dmem_req_ready),
    .rsp_valid_i    (dmem.dmem_rsp_valid),
    .req_valid_o    (dmem.dmem_req_valid),
    .req_we_o       (dmem.dmem_req_we),
    .stall_o        (stall_o),
    .rsp_capture_o  (rsp_capture),
    .timeout_hit_o  (timeout_hit),
    .dmem_timeout_o (dmem_timeout)
  );

  logic [XLEN-1:0] alu_result_q, mem_rdata_q, pc_plus4_q, imm_q;
  logic [4:0]      rd_waddr_q;
  logic [1:0]      wb_sel_q;
  logic            rd_wen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      mem_rdata_q  <= '0;
      pc_plus4_q   <= '0;
      imm_q        <= '0;
      rd_waddr_q   <= '0;
      wb_sel_q     <= WB_ALU;
      rd_wen_q     <= 1'b0;
    end else begin
      // A stalled cycle sends a bubble to WB and keeps the previous data fields.
      if (stall_o) begin
        rd_wen_q <= 1'b0;
      end else begin
        alu_result_q <= alu_result_M;
        pc_plus4_q   <= PC_M + XLEN'(4);
        imm_q        <= imm_M;
        rd_waddr_q   <= rd_waddr_M;
        wb_sel_q     <= PMAItoReg_M;
        rd_wen_q     <= rd_wen_M;
      end
      if (rsp_capture) begin
        mem_rdata_q <= dmem.dmem_rsp_rdata;
      end else if (timeout_hit) begin
        mem_rdata_q <= '0;
      end
    end
  end

  assign alu_result_W = alu_result_q;
  assign mem_rdata_W  = mem_rdata_q;
  assign pc_plus4_W   = pc_plus4_q;
  assign imm_W        = imm_q;
  assign rd_waddr_W   = rd_waddr_q;
  assign PMAItoReg_W  = wb_sel_q;
  assign rd_wen_W     = rd_wen_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios followed by random instructions,
// checked against a transaction-level model of stall length, request fields and WB contents.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic [31:0] PC_M, PC_branch_M, imm_M, rs2_rdata_M, alu_result_M;
  logic [4:0]  rd_waddr_M;
  logic        zero_M, branch_M, MemWrite_M, jal_M, jalr_M, rd_wen_M;
  logic [1:0]  PMAItoReg_M;
  logic        stall_o, PCSrc_M, dmem_timeout, rd_wen_W;
  logic [31:0] PC_target_M, alu_result_W, mem_rdata_W, pc_plus4_W, imm_W;
  logic [4:0]  rd_waddr_W;
  logic [1:0]  PMAItoReg_W;

  mem_stage_if #(.XLEN(32)) dif ();

  mem_stage #(.XLEN(32), .RSP_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .PC_M(PC_M), .PC_branch_M(PC_branch_M), .imm_M(imm_M),
    .rs2_rdata_M(rs2_rdata_M), .rd_waddr_M(rd_waddr_M), .zero_M(zero_M),
    .alu_result_M(alu_result_M), .branch_M(branch_M), .MemWrite_M(MemWrite_M),
    .jal_M(jal_M), .jalr_M(jalr_M), .PMAItoReg_M(PMAItoReg_M), .rd_wen_M(rd_wen_M),
    .dmem(dif.master), .stall_o(stall_o), .PCSrc_M(PCSrc_M), .PC_target_M(PC_target_M),
    .dmem_timeout(dmem_timeout), .alu_result_W(alu_result_W), .mem_rdata_W(mem_rdata_W),
    .pc_plus4_W(pc_plus4_W), .imm_W(imm_W), .rd_waddr_W(rd_waddr_W),
    .PMAItoReg_W(PMAItoReg_W), .rd_wen_W(rd_wen_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, mem, pc4, imm;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic        wen;
  } wb_t;

  wb_t model;
  int  vectors = 0;
  int  miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string ctx);
    chk({ctx, ".alu_W"}, alu_result_W, model.alu);
    chk({ctx, ".mem_W"}, mem_rdata_W, model.mem);
    chk({ctx, ".pc4_W"}, pc_plus4_W, model.pc4);
    chk({ctx, ".imm_W"}, imm_W, model.imm);
    chk({ctx, ".rd_W"}, 32'(rd_waddr_W), 32'(model.rd));
    chk({ctx, ".sel_W"}, 32'(PMAItoReg_W), 32'(model.sel));
    chk({ctx, ".wen_W"}, 32'(rd_wen_W), 32'(model.wen));
  endtask

  task automatic nop_fields();
    PC_M = '0; PC_branch_M = '0; imm_M = '0; rs2_rdata_M = '0; alu_result_M = '0;
    rd_waddr_M = '0; zero_M = 0; branch_M = 0; MemWrite_M = 0; jal_M = 0; jalr_M = 0;
    PMAItoReg_M = 2'b00; rd_wen_M = 0;
  endtask

  // kind: 0 ALU, 1 store, 2 load, 3 branch/jump
  task automatic rand_instr(input int kind);
    PC_M = $urandom; PC_branch_M = $urandom; imm_M = $urandom; rs2_rdata_M = $urandom;
    alu_result_M = $urandom; rd_waddr_M = 5'($urandom); zero_M = 1'($urandom);
    branch_M = 0; jal_M = 0; jalr_M = 0; MemWrite_M = 0;
    PMAItoReg_M = 2'($urandom); rd_wen_M = 1'($urandom);
    if (PMAItoReg_M == 2'b01 && kind != 2) rd_wen_M = 0;
    case (kind)
      1: MemWrite_M = 1;
      2: begin PMAItoReg_M = 2'b01; rd_wen_M = 1; end
      3: case ($urandom_range(0, 2))
           0: branch_M = 1;
           1: jal_M = 1;
           default: jalr_M = 1;
         endcase
      default: ;
    endcase
  endtask

  // Runs the instruction currently on the M inputs to completion.
  // r: cycles with ready low before acceptance; d: response arrives d cycles after the accept cycle.
  task automatic exec(input int r, input int d, input logic [31:0] rdata, input string tag);
    bit is_load, is_store, mem_op, to;
    int nst;
    is_load  = (PMAItoReg_M == 2'b01) && rd_wen_M;
    is_store = MemWrite_M;
    mem_op   = is_load || is_store;
    to       = is_load && (d > TO);
    nst      = is_store ? r : (is_load ? r + ((d > TO) ? TO : d) : 0);
    for (int c = 0; c <= nst; c++) begin
      dif.dmem_req_ready = mem_op ? (c >= r) : 1'($urandom);
      if (is_load && c > r) begin
        dif.dmem_rsp_valid = (c == r + d);
        dif.dmem_rsp_rdata = (c == r + d) ? rdata : $urandom;
      end else begin
        dif.dmem_rsp_valid = 1'($urandom);
        dif.dmem_rsp_rdata = $urandom;
      end
      #1;
      if (c == 0) begin
        chk({tag, ".pcsrc"}, 32'(PCSrc_M), 32'((branch_M && zero_M) || jal_M || jalr_M));
        chk({tag, ".target"}, PC_target_M,
            jalr_M ? (alu_result_M & 32'hFFFF_FFFE) : PC_branch_M);
      end
      chk({tag, ".stall"}, 32'(stall_o), 32'(c < nst));
      chk({tag, ".req_valid"}, 32'(dif.dmem_req_valid), 32'(mem_op && c <= r));
      if (mem_op && c <= r) begin
        chk({tag, ".req_we"}, 32'(dif.dmem_req_we), 32'(is_store));
        chk({tag, ".req_addr"}, dif.dmem_req_addr, alu_result_M);
        chk({tag, ".req_wdata"}, dif.dmem_req_wdata, rs2_rdata_M);
      end
      @(posedge clk); #1;
      if (c < nst) begin
        model.wen = 0;
      end else begin
        model.alu = alu_result_M; model.pc4 = PC_M + 32'd4; model.imm = imm_M;
        model.rd = rd_waddr_M; model.sel = PMAItoReg_M; model.wen = rd_wen_M;
        if (is_load) model.mem = to ? 32'h0 : rdata;
      end
      chk_wb(tag);
      chk({tag, ".timeout"}, 32'(dmem_timeout), 32'(c == nst && to));
    end
    dif.dmem_rsp_valid = 0;
  endtask

  initial begin
    rst_n = 0;
    nop_fields();
    dif.dmem_req_ready = 0; dif.dmem_rsp_valid = 0; dif.dmem_rsp_rdata = '0;
    model = '{default: '0};
    #12;
    chk_wb("reset");
    chk("reset.timeout", 32'(dmem_timeout), 32'h0);
    chk("reset.stall", 32'(stall_o), 32'h0);
    @(posedge clk); #1;
    rst_n = 1;

    // Store accepted immediately
    nop_fields(); MemWrite_M = 1; alu_result_M = 32'h100; rs2_rdata_M = 32'hDEADBEEF;
    PC_M = 32'h1000;
    exec(0, 0, 32'h0, "store_rdy");

    // Load, response 3 cycles after accept
    nop_fields(); PMAItoReg_M = 2'b01; rd_wen_M = 1; rd_waddr_M = 5'd5;
    alu_result_M = 32'h200; PC_M = 32'h1004;
    exec(0, 3, 32'h12345678, "load_d3");

    // Store with ready held low for 2 cycles
    nop_fields(); MemWrite_M = 1; alu_result_M = 32'h104; rs2_rdata_M = 32'hCAFEF00D;
    exec(2, 0, 32'h0, "store_wait");

    // Branch taken / not taken, jalr target alignment
    nop_fields(); branch_M = 1; zero_M = 1; PC_branch_M = 32'h40;
    exec(0, 0, 32'h0, "br_taken");
    nop_fields(); branch_M = 1; zero_M = 0; PC_branch_M = 32'h40;
    exec(0, 0, 32'h0, "br_not");
    nop_fields(); jalr_M = 1; alu_result_M = 32'h81; PMAItoReg_M = 2'b10; rd_wen_M = 1;
    exec(0, 0, 32'h0, "jalr");

    // Load with no response: times out
    nop_fields(); PMAItoReg_M = 2'b01; rd_wen_M = 1; rd_waddr_M = 5'd9;
    exec(1, 100, 32'h0, "load_to");

    // Load with response on the last cycle before the timeout
    nop_fields(); PMAItoReg_M = 2'b01; rd_wen_M = 1; rd_waddr_M = 5'd10;
    exec(0, TO, 32'hA5A5_5A5A, "load_d4");

    for (int i = 0; i < 150; i++) begin
      rand_instr($urandom_range(0, 3));
      exec($urandom_range(0, 2), $urandom_range(1, 6), $urandom, "rand");
    end

    // Reset in the middle of a load's wait for a response
    nop_fields(); PMAItoReg_M = 2'b01; rd_wen_M = 1; rd_waddr_M = 5'd3;
    dif.dmem_req_ready = 1; dif.dmem_rsp_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    nop_fields();
    #1;
    model = '{default: '0};
    chk_wb("midrst");
    chk("midrst.stall", 32'(stall_o), 32'h0);
    chk("midrst.req_valid", 32'(dif.dmem_req_valid), 32'h0);
    @(negedge clk);
    rst_n = 1;
    dif.dmem_rsp_valid = 1; dif.dmem_rsp_rdata = 32'hBADBAD00;
    #1;
    chk("midrst.late_rsp_stall", 32'(stall_o), 32'h0);
    @(posedge clk); #1;
    dif.dmem_rsp_valid = 0;
    model.pc4 = 32'd4;
    chk_wb("midrst.late_rsp");
    chk("midrst.timeout", 32'(dmem_timeout), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
